// File: rtl/sysmgr_reboot.sv
// Reboot/reset request controller: holds off after a request, then either pulses
// the clock manager reset or drives the SB_WARMBOOT inputs (terminal until rst_n).
module sysmgr_reboot #(
  parameter int DELAY_W = 16,
  parameter int PULSE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_reset,
  input  logic       req_boot,
  input  logic [1:0] req_sel,
  input  logic       cancel,
  output logic       busy,
  output logic       pll_rst,
  output logic       wb_boot,
  output logic [1:0] wb_sel,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] PULSE = 2'd2;
  localparam logic [1:0] BOOT  = 2'd3;

  localparam logic [DELAY_W-1:0] HOLD_ONE  = 1;
  localparam logic [PULSE_W-1:0] PULSE_ONE = 1;

  logic [1:0]         state;
  logic [DELAY_W-1:0] hold_cnt;
  logic [PULSE_W-1:0] pulse_cnt;
  logic               mode_boot;
  logic [1:0]         sel_q;

  assign dbg_state = state;

  // All outputs are registered; busy mirrors state != IDLE one edge at a time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      pulse_cnt <= '0;
      mode_boot <= 1'b0;
      sel_q     <= 2'b00;
      busy      <= 1'b0;
      pll_rst   <= 1'b0;
      wb_boot   <= 1'b0;
      wb_sel    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req_boot) begin
            mode_boot <= 1'b1;
            sel_q     <= req_sel;
            hold_cnt  <= '0;
            busy      <= 1'b1;
            state     <= HOLD;
          end else if (req_reset) begin
            mode_boot <= 1'b0;
            sel_q     <= 2'b00;
            hold_cnt  <= '0;
            busy      <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // cancel beats the terminal-count transition in the same cycle
          if (cancel) begin
            state     <= IDLE;
            busy      <= 1'b0;
            hold_cnt  <= '0;
            mode_boot <= 1'b0;
            sel_q     <= 2'b00;
          end else if (&hold_cnt) begin
            hold_cnt <= '0;
            if (mode_boot) begin
              wb_sel <= sel_q;
              state  <= BOOT;
            end else begin
              pll_rst   <= 1'b1;
              pulse_cnt <= '0;
              state     <= PULSE;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        PULSE: begin
          if (&pulse_cnt) begin
            pll_rst   <= 1'b0;
            busy      <= 1'b0;
            pulse_cnt <= '0;
            state     <= IDLE;
          end else begin
            pulse_cnt <= pulse_cnt + PULSE_ONE;
          end
        end
        BOOT: begin
          // wb_sel was loaded on entry, so BOOT rises one cycle behind it
          wb_boot <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysmgr_reboot.sv
// Directed bench for sysmgr_reboot with DELAY_W=4, PULSE_W=2.
// "cycle c" is the output value seen after the c-th rising edge of a scenario.
module tb_sysmgr_reboot;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_reset;
  logic       req_boot;
  logic [1:0] req_sel;
  logic       cancel;
  logic       busy;
  logic       pll_rst;
  logic       wb_boot;
  logic [1:0] wb_sel;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;

  sysmgr_reboot #(.DELAY_W(4), .PULSE_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_reset(req_reset), .req_boot(req_boot),
    .req_sel(req_sel), .cancel(cancel), .busy(busy), .pll_rst(pll_rst),
    .wb_boot(wb_boot), .wb_sel(wb_sel), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_reset = 1'b0;
    req_boot  = 1'b0;
    req_sel   = 2'b00;
    cancel    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, pll_rst, wb_boot, wb_sel} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b pll=%b boot=%b sel=%b want all 0",
               busy, pll_rst, wb_boot, wb_sel);
    end
  endtask

  task automatic test_reset_path();
    logic e_busy, e_pll;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      idle_inputs();
      req_reset = (c == 10);
      req_sel   = 2'b11;
      step();
      e_busy = (c + 1 >= 11) && (c + 1 <= 30);
      e_pll  = (c + 1 >= 27) && (c + 1 <= 30);
      checks++;
      if (busy !== e_busy || pll_rst !== e_pll || wb_boot !== 1'b0 || wb_sel !== 2'b00) begin
        failures++;
        $display("FAIL reset_path cycle %0d got busy=%b pll=%b boot=%b sel=%b want busy=%b pll=%b boot=0 sel=00",
                 c + 1, busy, pll_rst, wb_boot, wb_sel, e_busy, e_pll);
      end
    end
  endtask

  task automatic test_boot_path();
    logic       e_boot;
    logic [1:0] e_sel;
    do_reset();
    for (int c = 0; c < 128; c++) begin
      idle_inputs();
      req_boot  = (c == 10);
      req_sel   = (c == 10) ? 2'b10 : 2'b01;
      cancel    = (c == 50);
      req_reset = (c == 60);
      step();
      e_sel  = (c + 1 >= 27) ? 2'b10 : 2'b00;
      e_boot = (c + 1 >= 28);
      checks++;
      if (busy !== (c + 1 >= 11) || pll_rst !== 1'b0 || wb_boot !== e_boot || wb_sel !== e_sel) begin
        failures++;
        $display("FAIL boot_path cycle %0d got busy=%b pll=%b boot=%b sel=%b want busy=%b pll=0 boot=%b sel=%b",
                 c + 1, busy, pll_rst, wb_boot, wb_sel, (c + 1 >= 11), e_boot, e_sel);
      end
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({busy, pll_rst, wb_boot, wb_sel} !== 5'b0) begin
      failures++;
      $display("FAIL boot_exit_reset got busy=%b pll=%b boot=%b sel=%b want all 0",
               busy, pll_rst, wb_boot, wb_sel);
    end
  endtask

  task automatic test_both_same_cycle();
    logic       e_boot;
    logic [1:0] e_sel;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      idle_inputs();
      req_reset = (c == 10);
      req_boot  = (c == 10);
      req_sel   = (c == 10) ? 2'b01 : 2'b10;
      step();
      e_sel  = (c + 1 >= 27) ? 2'b01 : 2'b00;
      e_boot = (c + 1 >= 28);
      checks++;
      if (pll_rst !== 1'b0 || wb_boot !== e_boot || wb_sel !== e_sel) begin
        failures++;
        $display("FAIL both_req cycle %0d got pll=%b boot=%b sel=%b want pll=0 boot=%b sel=%b",
                 c + 1, pll_rst, wb_boot, wb_sel, e_boot, e_sel);
      end
    end
  endtask

  task automatic test_cancel();
    logic e_busy, e_pll;
    do_reset();
    for (int c = 0; c < 50; c++) begin
      idle_inputs();
      req_reset = (c == 10) || (c == 15) || (c == 21);
      cancel    = (c == 20) || (c == 5) || (c == 39);
      step();
      e_busy = ((c + 1 >= 11) && (c + 1 <= 20)) || ((c + 1 >= 22) && (c + 1 <= 41));
      e_pll  = (c + 1 >= 38) && (c + 1 <= 41);
      checks++;
      if (busy !== e_busy || pll_rst !== e_pll) begin
        failures++;
        $display("FAIL cancel cycle %0d got busy=%b pll=%b want busy=%b pll=%b",
                 c + 1, busy, pll_rst, e_busy, e_pll);
      end
    end
  endtask

  task automatic test_cancel_terminal();
    logic e_busy, e_pll;
    do_reset();
    for (int c = 0; c < 70; c++) begin
      idle_inputs();
      req_reset = (c == 10) || (c == 30) || (c == 48);
      cancel    = (c == 26);
      req_boot  = (c == 49);
      req_sel   = 2'b11;
      step();
      e_busy = ((c + 1 >= 11) && (c + 1 <= 26)) || ((c + 1 >= 31) && (c + 1 <= 50));
      e_pll  = (c + 1 >= 47) && (c + 1 <= 50);
      checks++;
      if (busy !== e_busy || pll_rst !== e_pll || wb_boot !== 1'b0 || wb_sel !== 2'b00) begin
        failures++;
        $display("FAIL cancel_terminal cycle %0d got busy=%b pll=%b boot=%b sel=%b want busy=%b pll=%b boot=0 sel=00",
                 c + 1, busy, pll_rst, wb_boot, wb_sel, e_busy, e_pll);
      end
    end
  endtask

  task automatic test_rst_mid_pulse();
    logic e_busy, e_pll;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      idle_inputs();
      rst_n     = (c != 28);
      req_reset = (c == 10) || (c == 35);
      step();
      e_busy = ((c + 1 >= 11) && (c + 1 <= 28)) || ((c + 1 >= 36) && (c + 1 <= 55));
      e_pll  = ((c + 1 >= 27) && (c + 1 <= 28)) || ((c + 1 >= 52) && (c + 1 <= 55));
      checks++;
      if (busy !== e_busy || pll_rst !== e_pll || wb_boot !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_pulse cycle %0d got busy=%b pll=%b boot=%b want busy=%b pll=%b boot=0",
                 c + 1, busy, pll_rst, wb_boot, e_busy, e_pll);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_reset_path();
    test_boot_path();
    test_both_same_cycle();
    test_cancel();
    test_cancel_terminal();
    test_rst_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
